// File: rtl/sram_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_master_pkg
// Purpose : Shared encodings and helpers for the byte-lane SRAM initiator.
//           The strobe and load-extend functions are also used by the
//           pipeline's store-to-load forwarding logic, so they stay pure
//           and self-contained.
// Contents: SIZE_* access-size encodings, FSM state encoding,
//           strobe_gen / lane_replicate / load_extend / req_is_bad.
// Revision: 1.0 - initial release
// ============================================================================
package sram_master_pkg;

  // Access size encoding as seen on req_size
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  // Byte write strobes for an access of the given size at byte offset a
  function automatic logic [3:0] strobe_gen(input logic [1:0] size,
                                            input logic [1:0] a);
    logic [3:0] s;
    case (size)
      SIZE_B:  s = 4'b0001 << a;
      SIZE_H:  s = 4'b0011 << a;
      SIZE_W:  s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Replicate right-aligned store data onto every lane it could land on
  function automatic logic [31:0] lane_replicate(input logic [1:0]  size,
                                                 input logic [31:0] wdata);
    logic [31:0] r;
    case (size)
      SIZE_B:  r = {4{wdata[7:0]}};
      SIZE_H:  r = {2{wdata[15:0]}};
      SIZE_W:  r = wdata;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Shift the addressed lane down to bit 0 and sign/zero extend it
  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  a,
                                              input logic [31:0] data);
    logic [31:0] lane;
    logic [31:0] r;
    lane = data >> {a, 3'b000};
    case (size)
      SIZE_B:  r = {{24{lane[7] & ~uns}}, lane[7:0]};
      SIZE_H:  r = {{16{lane[15] & ~uns}}, lane[15:0]};
      SIZE_W:  r = data;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Illegal size, or natural alignment violated
  function automatic logic req_is_bad(input logic [1:0] size,
                                      input logic [1:0] a);
    return (size == 2'b11) ||
           ((size == SIZE_H) && a[0]) ||
           ((size == SIZE_W) && (a != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : sram_lane_align
// Purpose : Purely combinational byte-lane datapath for sram_master.
// Ports   : chk_size/chk_addr_lo   - incoming request, checked for legality
//           acc_size/acc_addr_lo   - latched access being performed
//           acc_unsigned           - zero-extend loads
//           acc_wdata              - latched right-aligned store data
//           mem_rdata              - raw SRAM read word
//           strobe                 - byte strobes for the latched access
//           wdata_rep              - store data replicated across lanes
//           rdata_ext              - aligned, extended load data
//           req_bad                - incoming request misaligned/illegal
// Revision: 1.0 - initial release
// ============================================================================
module sram_lane_align
  import sram_master_pkg::*;
(
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_addr_lo,
  input  logic [1:0]  acc_size,
  input  logic [1:0]  acc_addr_lo,
  input  logic        acc_unsigned,
  input  logic [31:0] acc_wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  strobe,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        req_bad
);

  assign strobe    = strobe_gen(acc_size, acc_addr_lo);
  assign wdata_rep = lane_replicate(acc_size, acc_wdata);
  assign rdata_ext = load_extend(acc_size, acc_unsigned, acc_addr_lo, mem_rdata);
  assign req_bad   = req_is_bad(chk_size, chk_addr_lo);

endmodule
`default_nettype wire

// File: rtl/sram_master.sv
`default_nettype none
// ============================================================================
// Module  : sram_master
// Purpose : Single-outstanding load/store initiator for a byte-lane SRAM.
//           Accepts byte/half/word requests on a valid/ready handshake,
//           performs one word access (optionally stretched by WAIT_CYCLES),
//           and returns extended load data with a one-cycle resp_valid.
// Ports   : clk, rst (async, active-high)
//           req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/
//           req_wdata                           - request channel
//           resp_valid/resp_rdata/resp_err      - response channel
//           mem_addr/mem_read/mem_write/mem_di  - SRAM drive
//           mem_do                              - SRAM read data
// Revision: 1.0 - initial release
// ============================================================================
module sram_master
  import sram_master_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 14,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [WORD_ADDR_BITS-1:0] mem_addr,
  output logic                      mem_read,
  output logic [3:0]                mem_write,
  output logic [31:0]               mem_di,
  input  logic [31:0]               mem_do
);

  // Byte-address bits that actually reach the SRAM; higher bits wrap away
  localparam int ADDR_BITS = WORD_ADDR_BITS + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [3:0]            w_strobe;
  logic [31:0]           w_wdata_rep;
  logic [31:0]           w_rdata_ext;
  logic                  w_req_bad;
  logic                  w_last;

  if (ADDR_BITS < 32) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_BITS];
  end

  sram_lane_align u_align (
    .chk_size     (req_size),
    .chk_addr_lo  (req_addr[1:0]),
    .acc_size     (size_q),
    .acc_addr_lo  (addr_q[1:0]),
    .acc_unsigned (uns_q),
    .acc_wdata    (wdata_q),
    .mem_rdata    (mem_do),
    .strobe       (w_strobe),
    .wdata_rep    (w_wdata_rep),
    .rdata_ext    (w_rdata_ext),
    .req_bad      (w_req_bad)
  );

  // Final ACCESS cycle: the write strobe fires and load data is sampled
  assign w_last = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[ADDR_BITS-1:0];
          wdata_d = req_wdata;
          if (w_req_bad) begin
            // Rejected requests skip the SRAM entirely
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : w_rdata_ext;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // SRAM drive comes only from flops, so an async reset drops it at once and
  // write data is stable across the commit negedge
  assign mem_addr  = (state_q == ST_ACCESS) ? addr_q[ADDR_BITS-1:2] : '0;
  assign mem_read  = (state_q == ST_ACCESS) && !we_q;
  assign mem_write = (w_last && we_q) ? w_strobe : 4'b0000;
  assign mem_di    = (mem_write != 4'b0000) ? w_wdata_rep : 32'h0;

endmodule
`default_nettype wire
